// File: rtl/std_linear_sec_codec.sv
// std_linear_sec_codec: registered Hamming SEC encoder and decoder; code positions are 1..K, with parity bits at powers of two.
module std_linear_sec_codec #(
  parameter int P = 9,
  localparam int N = (1 << P) - 1 - P,
  localparam int K = N + P
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_word,
  output logic [K-1:0] o_codeword,
  input  logic [K-1:0] i_codeword,
  output logic [N-1:0] o_word,
  output logic         o_corrected
);
  logic [K-1:0] spread, enc, fixed;
  logic [N-1:0] dec;
  logic [P-1:0] par, syn;
  always_comb begin
    int d;
    d = 0;
    spread = '0;
    for (int j = 1; j <= K; j++)
      if ((j & (j - 1)) != 0) begin
        spread[j-1] = i_word[d];
        d++;
      end
  end
  always_comb begin
    par = '0;
    for (int i = 0; i < P; i++)
      for (int j = 1; j <= K; j++)
        if (j[i] && (j & (j - 1)) != 0) par[i] = par[i] ^ spread[j-1];
    enc = spread;
    for (int i = 0; i < P; i++) enc[(1 << i) - 1] = par[i];
  end
  always_comb begin
    syn = '0;
    for (int j = 1; j <= K; j++)
      if (i_codeword[j-1]) syn = syn ^ j[P-1:0];
  end
  // K = 2^P-1, so every nonzero syndrome names a real bit position
  always_comb begin
    int d;
    d = 0;
    fixed = i_codeword;
    if (syn != '0) fixed[syn - 1'b1] = ~i_codeword[syn - 1'b1];
    dec = '0;
    for (int j = 1; j <= K; j++)
      if ((j & (j - 1)) != 0) begin
        dec[d] = fixed[j-1];
        d++;
      end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_codeword  <= '0;
      o_word      <= '0;
      o_corrected <= 1'b0;
    end else begin
      o_codeword  <= enc;
      o_word      <= dec;
      o_corrected <= syn != '0;
    end
endmodule

// File: tb/tb_std_linear_sec_codec.sv
// tb_std_linear_sec_codec: P=3 directed/exhaustive checks plus a P=9 random encode->error->decode stream.
module tb_std_linear_sec_codec;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] w3 = '0, ow3;
  logic [6:0] cwi3 = '0, oc3;
  logic corr3, corr9;
  logic [501:0] w9 = '0, ow9;
  logic [510:0] oc9, err9 = '0, cwi9;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  assign cwi9 = oc9 ^ err9;

  std_linear_sec_codec #(.P(3)) u3 (.i_clk(clk), .i_rst_n(rst_n), .i_word(w3), .o_codeword(oc3),
    .i_codeword(cwi3), .o_word(ow3), .o_corrected(corr3));
  std_linear_sec_codec u9 (.i_clk(clk), .i_rst_n(rst_n), .i_word(w9), .o_codeword(oc9),
    .i_codeword(cwi9), .o_word(ow9), .o_corrected(corr9));

  task automatic check(input string tag, input logic [510:0] got, input logic [510:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Place data at non-power-of-two positions, then choose parity so the XOR of all set positions is zero
  function automatic logic [510:0] ref_enc(int p, logic [510:0] w);
    logic [510:0] c = '0;
    int d = 0;
    int x = 0;
    for (int j = 1; j < (1 << p); j++)
      if ((j & (j - 1)) != 0) begin
        c[j-1] = w[d];
        if (w[d]) x ^= j;
        d++;
      end
    for (int i = 0; i < p; i++) c[(1 << i) - 1] = x[i];
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [510:0] e, exp_cw;
    logic [501:0] prev_w;
    logic [510:0] prev_e;
    #2;
    check("rst_cw3", oc3, 0);
    check("rst_w3", ow3, 0);
    check("rst_c3", corr3, 0);
    check("rst_cw9", oc9, 0);
    @(negedge clk);
    rst_n = 1'b1;
    w3 = 4'hB; cwi3 = 7'h55;
    step();
    check("enc_b", oc3, 7'h55);
    check("dec_b", ow3, 4'hB);
    check("flag_b", corr3, 0);
    cwi3 = 7'h45;
    step();
    check("dec_45", ow3, 4'hB);
    check("flag_45", corr3, 1);
    cwi3 = 7'h54;
    step();
    check("dec_54", ow3, 4'hB);
    check("flag_54", corr3, 1);
    w3 = 4'h0;
    step();
    check("enc_0", oc3, 7'h00);
    w3 = 4'hF;
    step();
    check("enc_f", oc3, 7'h7F);
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 8; k++) begin
        e = (k == 0) ? '0 : (511'd1 << (k - 1));
        exp_cw = ref_enc(3, 511'(w));
        w3 = 4'(w);
        cwi3 = exp_cw[6:0] ^ e[6:0];
        step();
        check("sw_enc", oc3, exp_cw);
        check("sw_dec", ow3, 511'(w));
        check("sw_flag", corr3, 511'(k != 0));
      end
    prev_w = '0;
    prev_e = '0;
    for (int n = 0; n < 100; n++) begin
      for (int b = 0; b < 502; b += 32) w9[b +: 32] = (b + 32 <= 502) ? $urandom : 32'($urandom & 32'h3F);
      e = '0;
      if ($urandom_range(0, 3) != 0) e[$urandom_range(0, 510)] = 1'b1;
      err9 = e;
      step();
      check("p9_enc", oc9, ref_enc(9, 511'(w9)));
      check("p9_dec", ow9, 511'(prev_w));
      check("p9_flag", corr9, 511'($onehot(e)));
      prev_w = w9;
    end
    err9 = '0;
    w3 = 4'hF;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cw3", oc3, 0);
    check("mid_rst_cw9", oc9, 0);
    check("mid_rst_w9", ow9, 0);
    step();
    check("hold_rst_cw3", oc3, 0);
    check("hold_rst_w3", ow3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_cw3", oc3, 7'h7F);
    check("post_rst_cw9", oc9, ref_enc(9, 511'(w9)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/std_linear_sec_codec.md
# std_linear_sec_codec

Parameterised single-error-correcting (Hamming) codec with a registered encode path and a registered decode path. It protects data words that cross unreliable storage or links. The encode path turns an N-bit word into a K-bit codeword. The decode path accepts a K-bit codeword with at most one flipped bit and returns the original word plus a correction flag. It is the synthesizable, clocked packaging of the std_linear_sec_encoder / std_linear_sec_decoder code definition, and the two must agree bit-for-bit.

## Interface
- P, default 9: parity bit count, legal range 2..16.
- N, localparam, (1<<P)-1-P: data width (502 at default).
- K, localparam, N+P: codeword width (511 at default).

- i_clk  in  1  clock; all registers rise-edge triggered.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_word  in  N  data word to encode.
- o_codeword  out  K  registered codeword of i_word.
- i_codeword  in  K  received codeword, at most one bit in error.
- o_word  out  N  registered corrected data word.
- o_corrected  out  1  registered flag: a single-bit error was found and fixed.

## Operation
- Code definition:
  - Codeword bit index j carries code position j+1, so positions run 1..K.
  - Parity bits sit at positions 2^i, i=0..P-1.
  - Data bits fill the remaining positions in ascending order, i_word[0] first.
- Encode:
  - Parity at position 2^i is the XOR of all data bits whose position has bit i set.
  - The result is even parity per group, so the XOR of the positions of all 1-bits in a valid codeword is 0.
- Decode:
  - The syndrome S (P bits) has bit i equal to the XOR of all codeword bits whose position has bit i set. This includes the parity bit itself.
  - S==0: codeword is taken as-is and o_corrected=0.
  - S!=0: flip bit index S-1, then set o_corrected=1. S is always in 1..K, so every nonzero syndrome is correctable.
  - Extract data from the non-power-of-two positions in ascending order.
- Guarantees for any input word and any error vector with $onehot0:
  - o_word equals the original word.
  - o_corrected equals 1 exactly when one bit was flipped.
  - An error on a parity bit still sets o_corrected=1; the data is unchanged.
- Multi-bit errors are out of contract. The output is then a deterministic miscorrection, with no detection.
- Encode and decode paths are independent. They need not be chained, and no handshake exists: each is sampled every cycle.

## Timing
- Each path is combinational logic into one output register. Latency is exactly 1 cycle: inputs sampled at edge t appear on the outputs after edge t.
- Throughput is one word per cycle per path, fully pipelined.
- Reset:
  - i_rst_n low asynchronously clears o_codeword, o_word and o_corrected to 0, immediately and independent of the clock.
  - This holds mid-operation; in-flight results are discarded.
  - The outputs hold 0 while reset is low.
  - The first non-reset output is captured at the first rising edge with i_rst_n high.
- The all-zero reset values are self-consistent: codeword 0 is the encoding of word 0.

## Test plan
- P=3 (N=4, K=7), i_word=4'hB -> o_codeword=7'h55 one cycle later. Feed 7'h55 to i_codeword -> o_word=4'hB, o_corrected=0.
- P=3, i_codeword=7'h45 (bit 4 flipped) -> syndrome 5, o_word=4'hB, o_corrected=1. Also i_codeword=7'h54 (parity bit 0 flipped) -> o_word=4'hB, o_corrected=1.
- P=3, i_word=4'h0 -> 7'h00; i_word=4'hF -> 7'h7F. Exhaustive sweep: all 16 words x 8 error patterns (none or one-hot) gives correct word and flag.
- P=9, random words with random onehot0 errors through encode -> XOR -> decode: o_word equals the input word, and o_corrected equals $onehot(err), every cycle, with 1-cycle latency per stage.
- Reset: assert i_rst_n=0 between clock edges while outputs are nonzero -> all outputs 0 immediately. Release -> valid data after the next edge.
- Back-to-back: a new word every cycle for 100 cycles -> an output stream identical to the inputs, delayed 1 cycle (2 cycles through encode then decode), with no bubbles.
